i2c_write_engine: RTL and testbench

//  I2C master write serializer on the downstream side of the codec register-config sequencer.

---
 rtl/i2c_write_engine_if.sv | 25 ++
 rtl/i2c_write_engine.sv | 172 +++++++++++++++++
 tb/tb_i2c_write_engine.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_write_engine_if.sv
// Request side of the I2C write engine: one 24-bit word in, busy/strobe/ack out.
// Ports: start, i2c_data (requester -> engine); busy, tr_end, ack (engine -> requester).
interface i2c_write_engine_if;
  logic        start;
  logic [23:0] i2c_data;
  logic        busy;
  logic        tr_end;
  logic        ack;

  modport master (
    output start,
    output i2c_data,
    input  busy,
    input  tr_end,
    input  ack
  );

  modport slave (
    input  start,
    input  i2c_data,
    output busy,
    output tr_end,
    output ack
  );
endinterface

// File: rtl/i2c_write_engine.sv
// I2C master write serializer: START, 3 bytes + ACK slots, STOP, on a quarter-bit tick.
// Ports: clk, rst (sync active-low), req (slave modport), i2c_sclk (push-pull), i2c_sdin (open-drain).
module i2c_write_engine #(
  parameter int CLK_DIV = 625
) (
  input  logic              clk,
  input  logic              rst,
  i2c_write_engine_if.slave req,
  output logic              i2c_sclk,
  inout  wire               i2c_sdin
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_STOP,
    S_DONE
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_div;
  logic [1:0]    r_q, w_q;
  logic [3:0]    r_bit, w_bit;
  logic [1:0]    r_byte, w_byte;
  logic [23:0]   r_shift, w_shift;
  logic          r_nack, w_nack;
  logic          r_scl, w_scl;
  logic          r_sda_low, w_sda_low;
  logic          r_busy, w_busy;
  logic          r_tr_end, w_tr_end;
  logic          r_ack, w_ack;
  logic          r_start_d;
  logic          w_tick;
  logic          w_edge;

  // Divider parked at 0 in IDLE so the first tick lands CLK_DIV clks after accept.
  assign w_tick = (r_state != S_IDLE) &&
                  (r_div == CW'(CLK_DIV - 1));
  assign w_edge = req.start & ~r_start_d;

  assign req.busy   = r_busy;
  assign req.tr_end = r_tr_end;
  assign req.ack    = r_ack;
  assign i2c_sclk   = r_scl;
  assign i2c_sdin   = r_sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_q       <= '0;
      r_bit     <= '0;
      r_byte    <= '0;
      r_shift   <= '0;
      r_nack    <= 1'b0;
      r_scl     <= 1'b1;
      r_sda_low <= 1'b0;
      r_busy    <= 1'b0;
      r_tr_end  <= 1'b0;
      r_ack     <= 1'b0;
      r_start_d <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_div     <= (r_state == S_IDLE || w_tick) ?
                   '0 : r_div + CW'(1);
      r_q       <= w_q;
      r_bit     <= w_bit;
      r_byte    <= w_byte;
      r_shift   <= w_shift;
      r_nack    <= w_nack;
      r_scl     <= w_scl;
      r_sda_low <= w_sda_low;
      r_busy    <= w_busy;
      r_tr_end  <= w_tr_end;
      r_ack     <= w_ack;
      r_start_d <= req.start;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_q       = r_q;
    w_bit     = r_bit;
    w_byte    = r_byte;
    w_shift   = r_shift;
    w_nack    = r_nack;
    w_scl     = r_scl;
    w_sda_low = r_sda_low;
    w_busy    = r_busy;
    w_tr_end  = 1'b0;
    w_ack     = r_ack;
    unique case (r_state)
      S_IDLE: begin
        w_scl     = 1'b1;
        w_sda_low = 1'b0;
        w_busy    = 1'b0;
        if (w_edge) begin
          w_shift = req.i2c_data;
          w_busy  = 1'b1;
          w_ack   = 1'b0;
          w_nack  = 1'b0;
          w_q     = 2'd0;
          w_state = S_START;
        end
      end
      S_START: if (w_tick) begin
        if (r_q == 2'd0) begin
          w_sda_low = 1'b1;
          w_q       = 2'd1;
        end else begin
          w_scl   = 1'b0;
          w_q     = 2'd0;
          w_bit   = 4'd0;
          w_byte  = 2'd0;
          w_state = S_BIT;
        end
      end
      S_BIT: if (w_tick) begin
        w_q = r_q + 2'd1;
        unique case (r_q)
          2'd0: begin
            w_scl     = 1'b0;
            w_sda_low = (r_bit == 4'd8) ?
                        1'b0 : ~r_shift[23];
          end
          2'd1: w_scl = 1'b1;
          2'd2: begin
            // Slot 8 is the ACK slot; a released line is a NACK.
            if (r_bit == 4'd8 && i2c_sdin)
              w_nack = 1'b1;
          end
          2'd3: begin
            w_scl = 1'b0;
            if (r_bit != 4'd8) begin
              w_shift = {r_shift[22:0], 1'b0};
              w_bit   = r_bit + 4'd1;
            end else if (r_nack || r_byte == 2'd2) begin
              w_state = S_STOP;
            end else begin
              w_bit  = 4'd0;
              w_byte = r_byte + 2'd1;
            end
          end
        endcase
      end
      S_STOP: if (w_tick) begin
        if (r_q == 2'd0) begin
          w_sda_low = 1'b1;
          w_scl     = 1'b0;
          w_q       = 2'd1;
        end else if (r_q == 2'd1) begin
          w_scl = 1'b1;
          w_q   = 2'd2;
        end else begin
          w_sda_low = 1'b0;
          w_q       = 2'd0;
          w_tr_end  = 1'b1;
          w_ack     = r_nack;
          w_state   = S_DONE;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_write_engine.sv
// Bench for i2c_write_engine: bus monitor + ACK/NACK slave on SDA, directed and random words.
// Checks latency, ack, bytes on the bus, START/STOP counts, SCL period, reset abort.
module tb_i2c_write_engine;

  localparam int  CLK_DIV = 4;
  localparam int  TCLK    = 10;
  localparam time TPER    = 16 * TCLK;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl;
  wire  sda;

  i2c_write_engine_if bus ();

  i2c_write_engine #(
    .CLK_DIV(CLK_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (bus),
    .i2c_sclk(scl),
    .i2c_sdin(sda)
  );

  pullup (sda);

  logic slv_low = 1'b0;
  assign sda = slv_low ? 1'b0 : 1'bz;

  always #(TCLK / 2) clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Bus monitor and slave. nack_byte: 0..2 = NACK that byte, 3 = ACK all.
  int         nack_byte = 3;
  int         starts    = 0;
  int         stops     = 0;
  int         per_bad   = 0;
  logic [7:0] byte_q[$];
  logic       ackq[$];
  logic [7:0] m_acc     = 8'h00;
  int         m_bit     = 0;
  int         m_idx     = 0;
  bit         in_x      = 1'b0;
  bit         have_prev = 1'b0;
  time        prev_t    = 0;
  logic       p_scl     = 1'b1;
  logic       p_sda     = 1'b1;

  always @(scl or sda) begin
    if (scl === 1'b1 && p_scl === 1'b1 && sda !== p_sda) begin
      if (sda === 1'b0) begin
        starts++;
        in_x      = 1'b1;
        m_bit     = 0;
        m_idx     = 0;
        have_prev = 1'b0;
      end else begin
        stops++;
        in_x = 1'b0;
      end
    end else if (scl === 1'b1 && p_scl !== 1'b1) begin
      if (in_x) begin
        if (have_prev && ($time - prev_t) != TPER)
          per_bad++;
        prev_t    = $time;
        have_prev = 1'b1;
        if (m_bit < 8) begin
          m_acc = {m_acc[6:0], sda};
        end else begin
          byte_q.push_back(m_acc);
          ackq.push_back(sda);
        end
        m_bit++;
      end
    end else if (scl !== 1'b1 && p_scl === 1'b1) begin
      if (in_x) begin
        if (m_bit == 8) begin
          slv_low = (m_idx != nack_byte);
        end else if (m_bit == 9) begin
          slv_low = 1'b0;
          m_bit   = 0;
          m_idx++;
        end
      end
    end
    p_scl = scl;
    p_sda = sda;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Ticks from accept to tr_end, straight from the protocol shape.
  function automatic int exp_lat(input int nb);
    int ticks;
    if (nb > 2) ticks = 2 + 27 * 4 + 3;
    else        ticks = 2 + 36 * (nb + 1) + 3;
    return ticks * CLK_DIV;
  endfunction

  // mode 0: one-cycle start pulse; 1: start held high;
  // mode 2: pulse start and scramble data at accept+100.
  task automatic run_xfer(input logic [23:0] w,
                          input int nb,
                          input int mode);
    int n;
    int lowb;
    int q0;
    int s0;
    int p0;
    int nexp;
    bit got;
    nack_byte = nb;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    q0 = byte_q.size();
    s0 = starts;
    p0 = stops;
    bus.i2c_data = w;
    bus.start    = 1'b1;
    n    = 0;
    got  = 1'b0;
    lowb = 0;
    while (!got && n < 4000) begin
      @(negedge clk);
      n++;
      if (n == 1) chk("busy_accept", 32'(bus.busy), 1);
      if (n == 1 && mode != 1) bus.start = 1'b0;
      if (mode == 2 && n == 100) begin
        bus.start    = 1'b1;
        bus.i2c_data = 24'($urandom);
      end
      if (mode == 2 && n == 101) bus.start = 1'b0;
      if (bus.busy !== 1'b1) lowb++;
      if (bus.tr_end === 1'b1) got = 1'b1;
    end
    chk("tr_end_seen", 32'(got), 1);
    chk("latency", n - 1, exp_lat(nb));
    chk("busy_held", lowb, 0);
    chk("ack", 32'(bus.ack), 32'(nb < 3));
    @(negedge clk);
    chk("busy_after", 32'(bus.busy), 0);
    chk("tr_end_pulse", 32'(bus.tr_end), 0);
    nexp = (nb > 2) ? 3 : nb + 1;
    chk("nbytes", byte_q.size() - q0, nexp);
    for (int i = 0; i < nexp && q0 + i < byte_q.size(); i++) begin
      chk("byte", 32'(byte_q[q0 + i]), 32'(w[23 - 8 * i -: 8]));
      chk("ackbit", 32'(ackq[q0 + i]), 32'(i == nb));
    end
    chk("starts", starts - s0, 1);
    chk("stops", stops - p0, 1);
  endtask

  initial begin
    #(TCLK * 100000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi;
    int te;
    int per0;
    int s0;
    int p0;
    int nb;
    bus.start    = 1'b0;
    bus.i2c_data = 24'h0;
    rst          = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_tr_end", 32'(bus.tr_end), 0);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_scl", 32'(scl), 1);
    chk("rst_sda", 32'(sda), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);

    run_xfer(24'h341E00, 3, 0);
    run_xfer(24'h341E00, 0, 0);

    run_xfer(24'($urandom), 3, 1);
    hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.busy === 1'b1) hi++;
    end
    chk("held_start_once", hi, 0);

    run_xfer(24'($urandom), 3, 2);
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy === 1'b1) hi++;
    end
    chk("pulse_ignored", hi, 0);

    nack_byte = 3;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.i2c_data = 24'($urandom);
    bus.start    = 1'b1;
    n = 0;
    te = 0;
    repeat (200) begin
      @(negedge clk);
      n++;
      if (n == 1) bus.start = 1'b0;
      if (bus.tr_end === 1'b1) te++;
    end
    chk("mid_busy", 32'(bus.busy), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_scl", 32'(scl), 1);
    chk("abort_sda", 32'(sda), 1);
    chk("abort_busy", 32'(bus.busy), 0);
    repeat (3) begin
      @(negedge clk);
      if (bus.tr_end === 1'b1) te++;
    end
    rst = 1'b1;
    repeat (500) begin
      @(negedge clk);
      if (bus.tr_end === 1'b1) te++;
    end
    chk("abort_no_tr_end", te, 0);
    chk("abort_idle", 32'(bus.busy), 0);

    per0 = per_bad;
    s0   = starts;
    p0   = stops;
    for (int k = 0; k < 10; k++) begin
      nb = $urandom_range(0, 5);
      if (nb > 3) nb = 3;
      run_xfer(24'($urandom), nb, 0);
    end
    chk("scl_period", per_bad - per0, 0);
    chk("b2b_starts", starts - s0, 10);
    chk("b2b_stops", stops - p0, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
